// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: PC request, instruction-memory request/response, decode-side buffer output.
// FETCH_MISALIGN_TRAP_EN adds instr_misaligned alongside the buffer head.
interface fetch_unit_if #(
  parameter int N = 64
);
  logic [N-1:0] PC_in;
  logic         pc_valid;
  logic         pc_ready;
  logic         imem_req;
  logic [N-1:0] imem_addr;
  logic         imem_gnt;
  logic         imem_rvalid;
  logic [31:0]  imem_rdata;
  logic         instr_valid;
  logic [31:0]  instr_out;
  logic [N-1:0] instr_pc;
  logic         instr_ready;
  logic         flush;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic         instr_misaligned;
`endif

  // master: the fetch unit itself; slave: PC source, memory and decode around it
  modport master (
    input  PC_in, pc_valid, imem_gnt, imem_rvalid, imem_rdata, instr_ready, flush,
    output pc_ready, imem_req, imem_addr, instr_valid, instr_out, instr_pc
`ifdef FETCH_MISALIGN_TRAP_EN
    , output instr_misaligned
`endif
  );

  modport slave (
    output PC_in, pc_valid, imem_gnt, imem_rvalid, imem_rdata, instr_ready, flush,
    input  pc_ready, imem_req, imem_addr, instr_valid, instr_out, instr_pc
`ifdef FETCH_MISALIGN_TRAP_EN
    , input instr_misaligned
`endif
  );
endinterface

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch unit with a DEPTH-entry FIFO towards decode.
// Optional macro FETCH_MISALIGN_TRAP_EN: misaligned PCs bypass memory and enqueue a flagged NOP.
module fetch_unit #(
  parameter int N     = 64,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master bus
);
  localparam int          PW  = $clog2(DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RDATA, DRAIN} state_t;

  state_t        state, state_nxt;
  logic [N-1:0]  addr;
  logic          kill;
  logic [31:0]   buf_instr [DEPTH];
  logic [N-1:0]  buf_pc    [DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic [PW:0]   count;

  logic          accept, push, pop, mis_req, valid_int;
  logic [31:0]   push_instr;
  logic [N-1:0]  push_pc;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic          buf_mis [DEPTH];
  assign mis_req = (bus.PC_in[1:0] != 2'b00);
`else
  assign mis_req = 1'b0;
`endif

  // Only IDLE accepts, so nothing is in flight when count is compared against DEPTH
  assign bus.pc_ready = !rst && (state == IDLE) && !bus.flush && (count < (PW+1)'(DEPTH));
  assign accept       = bus.pc_valid && bus.pc_ready;

  assign push = (state == IDLE && accept && mis_req) ||
                (state == WAIT_RDATA && bus.imem_rvalid && !bus.flush);
  assign valid_int = !rst && (count != '0);
  assign pop  = valid_int && bus.instr_ready && !bus.flush;

  assign push_instr = (state == IDLE) ? NOP : bus.imem_rdata;
  assign push_pc    = (state == IDLE) ? bus.PC_in : addr;

  assign bus.imem_req  = !rst && (state == WAIT_GNT);
  assign bus.imem_addr = bus.imem_req ? {addr[N-1:2], 2'b00} : '0;

  assign bus.instr_valid = valid_int;
  assign bus.instr_out   = valid_int ? buf_instr[rptr] : '0;
  assign bus.instr_pc    = valid_int ? buf_pc[rptr]    : '0;
`ifdef FETCH_MISALIGN_TRAP_EN
  assign bus.instr_misaligned = valid_int && buf_mis[rptr];
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       if (accept && !mis_req) state_nxt = WAIT_GNT;
      // A request already on the bus is never withdrawn; a flush only marks its reply for discard
      WAIT_GNT:   if (bus.imem_gnt) state_nxt = (bus.flush || kill) ? DRAIN : WAIT_RDATA;
      WAIT_RDATA: begin
        if (bus.imem_rvalid)  state_nxt = IDLE;
        else if (bus.flush)   state_nxt = DRAIN;
      end
      DRAIN:      if (bus.imem_rvalid) state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      addr  <= '0;
      kill  <= 1'b0;
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      state <= state_nxt;
      if (accept) addr <= bus.PC_in;
      if (state == WAIT_GNT && !bus.imem_gnt) kill <= kill | bus.flush;
      else                                    kill <= 1'b0;
      if (bus.flush) begin
        rptr  <= wptr;
        count <= '0;
      end else begin
        if (push) wptr <= wptr + PW'(1);
        if (pop)  rptr <= rptr + PW'(1);
        count <= count + (PW+1)'(push) - (PW+1)'(pop);
      end
    end
  end

  // Buffer payload carries no reset; outputs are masked by instr_valid instead
  always_ff @(posedge clk) begin
    if (push) begin
      buf_instr[wptr] <= push_instr;
      buf_pc[wptr]    <= push_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
      buf_mis[wptr]   <= (state == IDLE);
`endif
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed plus randomized bench for fetch_unit against an in-order queue model of accepted fetches.
module tb_fetch_unit;
  localparam int          N     = 64;
  localparam int          DEPTH = 2;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  typedef struct packed {
    logic [31:0]  ins;
    logic [N-1:0] pc;
    logic         mis;
  } ent_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_unit_if #(.N(N)) bus ();
  fetch_unit #(.N(N), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  int passed = 0;
  int total  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] memw(input logic [N-1:0] a);
    return a[31:0] * 32'h9E37_79B1 + 32'h0123_4567 ^ a[63:32];
  endfunction

  function automatic ent_t expect_for(input logic [N-1:0] pc);
    ent_t e;
`ifdef FETCH_MISALIGN_TRAP_EN
    if (pc[1:0] != 2'b00) begin
      e.ins = NOP; e.pc = pc; e.mis = 1'b1;
      return e;
    end
`endif
    e.ins = memw({pc[N-1:2], 2'b00}); e.pc = pc; e.mis = 1'b0;
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.pc_valid = 1'b0; bus.PC_in = '0; bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0;
    bus.imem_rdata = '0; bus.instr_ready = 1'b0; bus.flush = 1'b0;
  endtask

  // Full aligned fetch from IDLE: accept, gdly wait cycles, grant, response
  task automatic fetch_one(input logic [N-1:0] pc, input logic [31:0] data, input int gdly);
    bus.pc_valid = 1'b1; bus.PC_in = pc; #1;
    check("accept_ready", bus.pc_ready, 1);
    step(); bus.pc_valid = 1'b0; bus.PC_in = '0;
    for (int i = 0; i < gdly; i++) begin
      #1;
      check("req_hold", bus.imem_req, 1);
      check("addr_hold", bus.imem_addr, pc);
      step();
    end
    bus.imem_gnt = 1'b1; #1;
    check("req_at_gnt", bus.imem_req, 1);
    check("addr_at_gnt", bus.imem_addr, pc);
    step(); bus.imem_gnt = 1'b0;
    bus.imem_rvalid = 1'b1; bus.imem_rdata = data;
    step(); bus.imem_rvalid = 1'b0; bus.imem_rdata = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    ent_t q[$];
    ent_t e;
    int rsp_dly;
    logic [N-1:0] rsp_addr, last_addr;
    bit req_open;

    // Reset state
    idle_inputs(); rst = 1'b1; bus.pc_valid = 1'b1;
    @(negedge clk); @(negedge clk); #1;
    check("rst_pc_ready", bus.pc_ready, 0);
    check("rst_imem_req", bus.imem_req, 0);
    check("rst_imem_addr", bus.imem_addr, 0);
    check("rst_instr_valid", bus.instr_valid, 0);
    check("rst_instr_out", bus.instr_out, 0);
    check("rst_instr_pc", bus.instr_pc, 0);
    rst = 1'b0; bus.pc_valid = 1'b0;
    step();

    // First fetch, minimum latency
    bus.pc_valid = 1'b1; bus.PC_in = '0; #1;
    check("first_pc_ready", bus.pc_ready, 1);
    step(); bus.pc_valid = 1'b0;
    bus.imem_gnt = 1'b1; #1;
    check("first_req", bus.imem_req, 1);
    check("first_addr", bus.imem_addr, 0);
    step(); bus.imem_gnt = 1'b0;
    bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h0050_0093; #1;
    check("first_not_yet_valid", bus.instr_valid, 0);
    step(); bus.imem_rvalid = 1'b0;
    #1;
    check("first_valid", bus.instr_valid, 1);
    check("first_out", bus.instr_out, 32'h0050_0093);
    check("first_pc", bus.instr_pc, 0);
    bus.instr_ready = 1'b1; step(); bus.instr_ready = 1'b0; #1;
    check("first_consumed", bus.instr_valid, 0);

    // Fill the buffer, back-pressure, then ordered drain
    fetch_one(64'h0, 32'h1111_0000, 0);
    fetch_one(64'h4, 32'h1111_0004, 0);
    bus.pc_valid = 1'b1; bus.PC_in = 64'h8; #1;
    check("full_pc_ready", bus.pc_ready, 0);
    check("full_head_out", bus.instr_out, 32'h1111_0000);
    step(); #1;
    check("head_stable_out", bus.instr_out, 32'h1111_0000);
    check("head_stable_pc", bus.instr_pc, 0);
    bus.instr_ready = 1'b1; step(); #1;
    check("second_out", bus.instr_out, 32'h1111_0004);
    check("second_pc", bus.instr_pc, 64'h4);
    check("ready_after_pop", bus.pc_ready, 1);
    bus.pc_valid = 1'b0;
    fetch_one(64'h8, 32'h1111_0008, 0);
    #1;
    check("third_out", bus.instr_out, 32'h1111_0008);
    check("third_pc", bus.instr_pc, 64'h8);
    step(); #1;
    check("drained", bus.instr_valid, 0);

    // Grant delayed five cycles
    fetch_one(64'h10, 32'h2222_0010, 5);
    #1;
    check("slow_out", bus.instr_out, 32'h2222_0010);
    check("slow_pc", bus.instr_pc, 64'h10);
    step(); bus.instr_ready = 1'b0;

    // Flush in WAIT_RDATA, late response discarded
    bus.pc_valid = 1'b1; bus.PC_in = 64'h20; step(); bus.pc_valid = 1'b0;
    bus.imem_gnt = 1'b1; step(); bus.imem_gnt = 1'b0;
    bus.flush = 1'b1; #1;
    check("flush_pc_ready", bus.pc_ready, 0);
    step(); bus.flush = 1'b0;
    bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hDEAD_BEEF; #1;
    check("drain_pc_ready", bus.pc_ready, 0);
    step(); bus.imem_rvalid = 1'b0; #1;
    check("drain_no_valid", bus.instr_valid, 0);
    check("drain_back_idle", bus.pc_ready, 1);
    fetch_one(64'h100, 32'h3333_0100, 1);
    #1;
    check("after_flush_out", bus.instr_out, 32'h3333_0100);
    check("after_flush_pc", bus.instr_pc, 64'h100);

    // Flush with a buffered entry, coincident with instr_ready
    bus.flush = 1'b1; bus.instr_ready = 1'b1; step();
    bus.flush = 1'b0; bus.instr_ready = 1'b0; #1;
    check("flush_empties", bus.instr_valid, 0);

    // Flush in WAIT_GNT: request held until grant, reply discarded
    bus.pc_valid = 1'b1; bus.PC_in = 64'h40; step(); bus.pc_valid = 1'b0;
    bus.flush = 1'b1; step(); bus.flush = 1'b0; #1;
    check("gnt_flush_req_held", bus.imem_req, 1);
    check("gnt_flush_addr_held", bus.imem_addr, 64'h40);
    bus.imem_gnt = 1'b1; step(); bus.imem_gnt = 1'b0;
    bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h4444_0040; step(); bus.imem_rvalid = 1'b0; #1;
    check("gnt_flush_no_valid", bus.instr_valid, 0);
    check("gnt_flush_idle", bus.pc_ready, 1);

    // Reset while waiting for data
    bus.pc_valid = 1'b1; bus.PC_in = 64'h50; step(); bus.pc_valid = 1'b0;
    bus.imem_gnt = 1'b1; step(); bus.imem_gnt = 1'b0;
    rst = 1'b1; #1;
    check("midrst_req", bus.imem_req, 0);
    check("midrst_pc_ready", bus.pc_ready, 0);
    step(); rst = 1'b0;
    bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h5555_0050; #1;
    check("postrst_idle", bus.pc_ready, 1);
    step(); bus.imem_rvalid = 1'b0; #1;
    check("postrst_no_valid", bus.instr_valid, 0);

    // Misaligned PC
`ifdef FETCH_MISALIGN_TRAP_EN
    bus.pc_valid = 1'b1; bus.PC_in = 64'h6; #1;
    check("mis_ready", bus.pc_ready, 1);
    step(); bus.pc_valid = 1'b0; #1;
    check("mis_no_req", bus.imem_req, 0);
    check("mis_valid", bus.instr_valid, 1);
    check("mis_out", bus.instr_out, NOP);
    check("mis_flag", bus.instr_misaligned, 1);
    check("mis_pc", bus.instr_pc, 64'h6);
`else
    bus.pc_valid = 1'b1; bus.PC_in = 64'h6; step(); bus.pc_valid = 1'b0; #1;
    check("mis_req", bus.imem_req, 1);
    check("mis_addr", bus.imem_addr, 64'h4);
    bus.imem_gnt = 1'b1; step(); bus.imem_gnt = 1'b0;
    bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h6666_0004; step(); bus.imem_rvalid = 1'b0; #1;
    check("mis_out", bus.instr_out, 32'h6666_0004);
    check("mis_pc", bus.instr_pc, 64'h6);
`endif
    bus.instr_ready = 1'b1; step(); bus.instr_ready = 1'b0;

    // Randomized traffic against the queue model
    rsp_dly = -1; rsp_addr = '0; last_addr = '0; req_open = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bit draining;
      draining = (cyc >= 2800);
      bus.flush       = !draining && ($urandom_range(0, 19) == 0);
      bus.pc_valid    = !draining && ($urandom_range(0, 1) == 1);
      bus.PC_in       = {$urandom, $urandom};
      bus.instr_ready = draining || ($urandom_range(0, 2) != 0);
      bus.imem_gnt    = ($urandom_range(0, 2) == 0);
      if (rsp_dly == 0) begin
        bus.imem_rvalid = 1'b1; bus.imem_rdata = memw(rsp_addr);
      end else if (rsp_dly < 0 && $urandom_range(0, 9) == 0) begin
        bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hBAD0_0BAD;
      end else begin
        bus.imem_rvalid = 1'b0; bus.imem_rdata = $urandom;
      end
      #1;
      if (req_open) begin
        check("rnd_req_stable", bus.imem_req, 1);
        check("rnd_addr_stable", bus.imem_addr, last_addr);
      end
      if (bus.imem_req) check("rnd_addr_aligned", bus.imem_addr[1:0], 0);
      req_open  = bus.imem_req && !bus.imem_gnt;
      last_addr = bus.imem_addr;
      if (rsp_dly == 0) rsp_dly = -1;
      else if (rsp_dly > 0) rsp_dly--;
      if (bus.imem_req && bus.imem_gnt) begin
        rsp_addr = bus.imem_addr;
        rsp_dly  = $urandom_range(0, 3);
      end

      if (bus.pc_ready) check("rnd_space", q.size() < DEPTH, 1);
      if (bus.flush) begin
        q.delete();
      end else if (bus.instr_valid && bus.instr_ready) begin
        check("rnd_valid_has_entry", q.size() != 0, 1);
        if (q.size() != 0) begin
          e = q.pop_front();
          check("rnd_instr_out", bus.instr_out, e.ins);
          check("rnd_instr_pc", bus.instr_pc, e.pc);
`ifdef FETCH_MISALIGN_TRAP_EN
          check("rnd_misaligned", bus.instr_misaligned, e.mis);
`endif
        end
      end
      if (bus.pc_valid && bus.pc_ready) q.push_back(expect_for(bus.PC_in));
      step();
    end
    #1;
    check("rnd_all_delivered", q.size(), 0);
    check("rnd_final_empty", bus.instr_valid, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
